// File: rtl/crossbar_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crossbar_pkg                                                         |
// | Shared types and sizing helper for the crossbar and its scheduler.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package crossbar_pkg;

    typedef enum logic [0:0] {
        XB_IDLE = 1'b0,
        XB_BUSY = 1'b1
    } xb_state_t;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin pick: first request at index >= pointer,   |
// | wrapping to the lowest request otherwise.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N     = 3,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic             w_hi_any;
    logic [SEL_W-1:0] w_hi_idx;
    logic             w_lo_any;
    logic [SEL_W-1:0] w_lo_idx;

    // Descending scan so the last write is the lowest matching index.
    always_comb begin
        w_hi_any = 1'b0;
        w_hi_idx = '0;
        w_lo_any = 1'b0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_any = 1'b1;
                w_lo_idx = SEL_W'(i);
                if (SEL_W'(i) >= i_ptr) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = SEL_W'(i);
                end
            end
        end
    end

    assign o_any = w_lo_any;
    assign o_idx = w_hi_any ? w_hi_idx : w_lo_idx;

endmodule
`default_nettype wire

// File: rtl/crossbar_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crossbar_scheduler                                                   |
// | Per-output packet lock with round-robin grant; drives crossbar select.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module crossbar_scheduler
    import crossbar_pkg::*;
#(
    parameter int N     = 3,
    parameter int SEL_W = sel_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*SEL_W-1:0] in_dest,
    input  logic [N-1:0]       in_last,
    input  logic [N-1:0]       out_ready,
    output logic [N-1:0]       in_ready,
    output logic [N-1:0]       out_valid,
    output logic [N*SEL_W-1:0] select,
    output logic [N-1:0]       out_busy
);

    xb_state_t        r_state     [N];
    xb_state_t        w_state_nxt [N];
    logic [SEL_W-1:0] r_owner     [N];
    logic [SEL_W-1:0] w_owner_nxt [N];
    logic [SEL_W-1:0] r_ptr       [N];
    logic [SEL_W-1:0] w_ptr_nxt   [N];
    logic [SEL_W-1:0] w_win_idx   [N];
    logic [N-1:0]     w_win_any;
    logic [N-1:0]     w_owned;
    logic [N-1:0]     w_req       [N];

    // Inputs already holding a lock are masked so none can own two outputs.
    always_comb begin
        w_owned = '0;
        for (int o = 0; o < N; o++) begin
            if (r_state[o] == XB_BUSY) w_owned[r_owner[o]] = 1'b1;
        end
        for (int o = 0; o < N; o++) begin
            w_req[o] = '0;
            for (int i = 0; i < N; i++) begin
                w_req[o][i] = in_valid[i] && !w_owned[i] &&
                              (in_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_arb
        rr_arbiter #(
            .N     (N),
            .SEL_W (SEL_W)
        ) u_arb (
            .i_req (w_req[o]),
            .i_ptr (r_ptr[o]),
            .o_idx (w_win_idx[o]),
            .o_any (w_win_any[o])
        );
    end

    always_comb begin
        in_ready  = '0;
        out_valid = '0;
        out_busy  = '0;
        select    = '0;
        for (int o = 0; o < N; o++) begin
            select[o*SEL_W +: SEL_W] = r_owner[o];
            if (r_state[o] == XB_BUSY) begin
                out_busy[o]  = 1'b1;
                out_valid[o] = in_valid[r_owner[o]];
                if (out_ready[o]) in_ready[r_owner[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < N; o++) begin
            w_state_nxt[o] = r_state[o];
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
            if (r_state[o] == XB_IDLE) begin
                if (w_win_any[o]) begin
                    w_state_nxt[o] = XB_BUSY;
                    w_owner_nxt[o] = w_win_idx[o];
                end
            end else if (in_valid[r_owner[o]] && out_ready[o] && in_last[r_owner[o]]) begin
                w_state_nxt[o] = XB_IDLE;
                w_ptr_nxt[o]   = (r_owner[o] == SEL_W'(N - 1)) ? '0 : r_owner[o] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < N; o++) begin
            if (rst) begin
                r_state[o] <= XB_IDLE;
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end else begin
                r_state[o] <= w_state_nxt[o];
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crossbar_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crossbar_scheduler                                                |
// | Directed scenarios plus randomized traffic against a reference model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_crossbar_scheduler;

    localparam int N  = 3;
    localparam int SW = 2;
    localparam logic [2:0] CONT_TBL [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                                            3'b000, 3'b100, 3'b000, 3'b001};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    in_valid, in_last, out_ready;
    logic [N*SW-1:0] in_dest;
    logic [N-1:0]    in_ready, out_valid, out_busy;
    logic [N*SW-1:0] sel;

    logic [3:0] v4_valid, v4_last, v4_oready, v4_irdy, v4_ovalid, v4_busy;
    logic [7:0] v4_dest, v4_sel;

    crossbar_scheduler #(.N(N)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dest(in_dest),
        .in_last(in_last), .out_ready(out_ready), .in_ready(in_ready),
        .out_valid(out_valid), .select(sel), .out_busy(out_busy)
    );

    crossbar_scheduler #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4_valid), .in_dest(v4_dest),
        .in_last(v4_last), .out_ready(v4_oready), .in_ready(v4_irdy),
        .out_valid(v4_ovalid), .select(v4_sel), .out_busy(v4_busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model for the N=3 instance: lock flag, owner and pointer per output.
    bit              m_busy  [N];
    int              m_owner [N];
    int              m_ptr   [N];
    logic [N-1:0]    e_rdy, e_ov, e_busy;
    logic [N*SW-1:0] e_sel;

    function automatic int dest_of(input int i);
        return int'(in_dest[i*SW +: SW]);
    endfunction

    task automatic model_comb();
        e_rdy = '0; e_ov = '0; e_busy = '0; e_sel = '0;
        for (int o = 0; o < N; o++) begin
            e_sel[o*SW +: SW] = SW'(m_owner[o]);
            if (m_busy[o]) begin
                e_busy[o] = 1'b1;
                e_ov[o]   = in_valid[m_owner[o]];
                if (out_ready[o]) e_rdy[m_owner[o]] = 1'b1;
            end
        end
    endtask

    task automatic model_clock();
        bit owned [N];
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                m_busy[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) owned[i] = 1'b0;
            for (int o = 0; o < N; o++) if (m_busy[o]) owned[m_owner[o]] = 1'b1;
            for (int o = 0; o < N; o++) begin
                if (m_busy[o]) begin
                    if (in_valid[m_owner[o]] && out_ready[o] && in_last[m_owner[o]]) begin
                        m_busy[o] = 1'b0;
                        m_ptr[o]  = (m_owner[o] + 1) % N;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr[o] + k) % N;
                        if (!m_busy[o] && in_valid[c] && dest_of(c) == o && !owned[c]) begin
                            m_busy[o]  = 1'b1;
                            m_owner[o] = c;
                        end
                    end
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input bit v, input int d, input bit l);
        in_valid[i]         = v;
        in_dest[i*SW +: SW] = SW'(d);
        in_last[i]          = l;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '1; in_dest = '0; in_last = '0; out_ready = '1;
        v4_valid = '1; v4_dest = '0; v4_last = '0; v4_oready = '1;
        advance();
        advance();
        #1;
        total++;
        if ({in_ready, out_valid, out_busy, sel} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b sel=%b, required all zero", in_ready, out_valid, out_busy, sel);
        end
        total++;
        if ({v4_irdy, v4_ovalid, v4_busy, v4_sel} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_n4: rdy=%b ov=%b busy=%b sel=%b, required all zero", v4_irdy, v4_ovalid, v4_busy, v4_sel);
        end
        rst = 1'b0; in_valid = '0; v4_valid = '0;
        advance();
        #1;
        total++;
        if (out_busy !== 3'b000 || sel !== 6'b0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b sel=%b, required 000 / 000000", out_busy, sel);
        end
    endtask

    task automatic test_single_packet();
        out_ready = '1;
        set_in(1, 1'b1, 2, 1'b0);
        #1;
        total++;
        if (out_busy !== 3'b000 || in_ready !== 3'b000) begin
            bad++;
            $display("FAIL single_request_cycle: busy=%b rdy=%b, required 000 / 000", out_busy, in_ready);
        end
        advance();
        for (int b = 0; b < 3; b++) begin
            in_last[1] = (b == 2);
            #1;
            total++;
            if (out_busy !== 3'b100 || sel[5:4] !== 2'd1 || in_ready !== 3'b010 || out_valid !== 3'b100) begin
                bad++;
                $display("FAIL single_beat%0d: busy=%b sel2=%0d rdy=%b ov=%b, required 100 / 1 / 010 / 100", b, out_busy, sel[5:4], in_ready, out_valid);
            end
            advance();
        end
        in_valid = '0;
        #1;
        total++;
        if (out_busy !== 3'b000 || sel[5:4] !== 2'd1 || u_dut3.r_ptr[2] !== 2'd2) begin
            bad++;
            $display("FAIL single_release: busy=%b sel2=%0d ptr2=%0d, required 000 / 1 / 2", out_busy, sel[5:4], u_dut3.r_ptr[2]);
        end
    endtask

    task automatic test_contention();
        out_ready = '1;
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            #1;
            total++;
            if (in_ready !== CONT_TBL[c]) begin
                bad++;
                $display("FAIL contention_c%0d: rdy=%b, required %b", c, in_ready, CONT_TBL[c]);
            end
            if (c == 6) begin
                total++;
                if (u_dut3.r_ptr[0] !== 2'd0) begin
                    bad++;
                    $display("FAIL contention_ptr_wrap: ptr0=%0d, required 0", u_dut3.r_ptr[0]);
                end
            end
            advance();
        end
        in_valid = '0;
        advance();
    endtask

    task automatic test_backpressure();
        int beats;
        beats = 0;
        out_ready = '1;
        set_in(2, 1'b1, 0, 1'b0);
        #1;
        total++;
        if (in_ready !== 3'b000) begin
            bad++;
            $display("FAIL bp_request_cycle: rdy=%b, required 000", in_ready);
        end
        advance();
        for (int c = 1; c < 8; c++) begin
            out_ready[0] = !(c >= 2 && c <= 5);
            in_last[2]   = (beats == 2);
            #1;
            model_comb();
            total++;
            if (in_ready !== e_rdy) begin
                bad++;
                $display("FAIL bp_ready_c%0d: rdy=%b, required %b", c, in_ready, e_rdy);
            end
            if (c >= 2 && c <= 5) begin
                total++;
                if (in_ready !== 3'b000 || out_busy[0] !== 1'b1 || out_valid[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_stall_c%0d: rdy=%b busy0=%b ov0=%b, required 000 / 1 / 1", c, in_ready, out_busy[0], out_valid[0]);
                end
            end
            if (in_valid[2] && in_ready[2]) beats++;
            advance();
        end
        in_valid = '0;
        #1;
        total++;
        if (beats !== 3 || out_busy !== 3'b000) begin
            bad++;
            $display("FAIL bp_beat_count: beats=%0d busy=%b, required 3 / 000", beats, out_busy);
        end
    endtask

    task automatic test_parallel();
        in_valid = '0; out_ready = '1;
        set_in(0, 1'b1, 1, 1'b1);
        set_in(2, 1'b1, 0, 1'b1);
        #1;
        total++;
        if (out_busy !== 3'b000) begin
            bad++;
            $display("FAIL par_request_cycle: busy=%b, required 000", out_busy);
        end
        advance();
        out_ready = 3'b001;
        #1;
        total++;
        if (out_busy !== 3'b011 || sel !== {2'd1, 2'd0, 2'd2} || in_ready !== 3'b100) begin
            bad++;
            $display("FAIL par_grant: busy=%b sel=%b rdy=%b, required 011 / 010010 / 100", out_busy, sel, in_ready);
        end
        advance();
        in_valid[2] = 1'b0; out_ready = '1;
        #1;
        total++;
        if (out_busy !== 3'b010 || in_ready !== 3'b001) begin
            bad++;
            $display("FAIL par_independent_release: busy=%b rdy=%b, required 010 / 001", out_busy, in_ready);
        end
        advance();
        in_valid = '0;
        #1;
        total++;
        if (out_busy !== 3'b000) begin
            bad++;
            $display("FAIL par_both_released: busy=%b, required 000", out_busy);
        end
    endtask

    task automatic test_random();
        int pkt_left [N];
        int pkt_dest [N];
        for (int i = 0; i < N; i++) begin pkt_left[i] = 0; pkt_dest[i] = 0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (pkt_left[i] == 0 && $urandom_range(0, 1) == 1) begin
                    pkt_left[i] = $urandom_range(1, 4);
                    pkt_dest[i] = $urandom_range(0, N - 1);
                end
                set_in(i, (pkt_left[i] > 0) && ($urandom_range(0, 4) != 0), pkt_dest[i], pkt_left[i] == 1);
            end
            out_ready = N'($urandom) | N'($urandom);
            #1;
            model_comb();
            total++;
            if (in_ready !== e_rdy || out_valid !== e_ov || out_busy !== e_busy || sel !== e_sel) begin
                bad++;
                $display("FAIL random_c%0d: rdy=%b ov=%b busy=%b sel=%b, required %b %b %b %b", c, in_ready, out_valid, out_busy, sel, e_rdy, e_ov, e_busy, e_sel);
            end
            for (int i = 0; i < N; i++) if (in_valid[i] && e_rdy[i]) pkt_left[i]--;
            advance();
        end
        in_valid = '0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        advance();
        rst = 1'b0; out_ready = '1;
        set_in(1, 1'b1, 2, 1'b0);
        advance();
        advance();
        #1;
        total++;
        if (out_busy !== 3'b100) begin
            bad++;
            $display("FAIL rmid_locked: busy=%b, required 100", out_busy);
        end
        rst = 1'b1;
        advance();
        #1;
        total++;
        if (out_busy !== 3'b000 || in_ready !== 3'b000 || sel !== 6'b0 || u_dut3.r_ptr[2] !== 2'd0) begin
            bad++;
            $display("FAIL rmid_cleared: busy=%b rdy=%b sel=%b ptr2=%0d, required 000 / 000 / 000000 / 0", out_busy, in_ready, sel, u_dut3.r_ptr[2]);
        end
        rst = 1'b0; in_valid = '0;
        advance();
    endtask

    task automatic test_invalid_dest();
        in_valid = '0; out_ready = '1;
        set_in(0, 1'b1, 3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (in_ready !== 3'b000 || out_busy !== 3'b000 || out_valid !== 3'b000) begin
                bad++;
                $display("FAIL invalid_dest_c%0d: rdy=%b busy=%b ov=%b, required all 000", c, in_ready, out_busy, out_valid);
            end
            advance();
        end
        in_valid = '0;
    endtask

    task automatic test_n4();
        v4_oready = '1; v4_valid = 4'b0010; v4_dest = '0; v4_dest[3:2] = 2'd3; v4_last = 4'b0010;
        #1;
        total++;
        if (v4_busy !== 4'b0000) begin
            bad++;
            $display("FAIL n4_request_cycle: busy=%b, required 0000", v4_busy);
        end
        advance();
        #1;
        total++;
        if (v4_busy !== 4'b1000 || v4_sel[7:6] !== 2'd1 || v4_irdy !== 4'b0010 || v4_ovalid !== 4'b1000) begin
            bad++;
            $display("FAIL n4_grant: busy=%b sel3=%0d rdy=%b ov=%b, required 1000 / 1 / 0010 / 1000", v4_busy, v4_sel[7:6], v4_irdy, v4_ovalid);
        end
        advance();
        v4_valid = '0;
        #1;
        total++;
        if (v4_busy !== 4'b0000 || u_dut4.r_ptr[3] !== 2'd2) begin
            bad++;
            $display("FAIL n4_release: busy=%b ptr3=%0d, required 0000 / 2", v4_busy, u_dut4.r_ptr[3]);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; in_dest = '0; out_ready = '0;
        v4_valid = '0; v4_last = '0; v4_dest = '0; v4_oready = '0;
        for (int o = 0; o < N; o++) begin m_busy[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0; end
        test_reset();
        test_single_packet();
        test_contention();
        test_backpressure();
        test_parallel();
        test_random();
        test_reset_mid();
        test_invalid_dest();
        test_n4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/crossbar_scheduler.md
# crossbar_scheduler

Control-plane companion to the crossbar switch: accepts per-input packet requests (valid, destination, last) and produces the crossbar `select` vector, per-input `in_ready` and per-output `out_valid`. Each output is granted to one input at a time, held for a whole packet and released on the last beat, with round-robin fairness. Sits beside the crossbar; its `select` output drives the crossbar `select` input directly, in the same packed layout.

## Interface
- `N`, default 3: number of crossbar inputs/outputs (N ≥ 2).
- `SEL_W`, default `$clog2(N)`: width of one destination/select field; derived, not overridden.

- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  N: bit i = input i has a beat pending.
- `in_dest`  in  N*SEL_W: field i (`[i*SEL_W +: SEL_W]`) = destination output of input i; stable while `in_valid[i]`=1.
- `in_last`  in  N: bit i = current beat of input i ends its packet.
- `out_ready`  in  N: bit o = downstream of output o accepts a beat.
- `in_ready`  out  N: bit i = beat of input i transfers this cycle if `in_valid[i]`.
- `out_valid`  out  N: bit o = output o carries a valid beat.
- `select`  out  N*SEL_W: field o = input index routed to output o; same packing as the crossbar `select`.
- `out_busy`  out  N: bit o = output o is locked to an owner.

## Operation
- Per output o: state IDLE or BUSY, registered `owner[o]` (SEL_W), registered round-robin pointer `ptr[o]` (SEL_W).
- Requester set for o: inputs i with `in_valid[i]` and `in_dest[i]`==o. Destinations ≥ N are never granted (input stalls forever, `in_ready`=0).
- IDLE: if requester set non-empty, winner = first requester at index ≥ `ptr[o]`, wrapping past N-1 to 0; next cycle `owner[o]`←winner, state←BUSY. No transfer in IDLE.
- BUSY: `select[o]`=`owner[o]`; `out_valid[o]`=`in_valid[owner]`; `in_ready[owner]`=`out_ready[o]`. Beat transfers when `in_valid[owner]` and `out_ready[o]`.
- Transfer with `in_last[owner]`=1: state←IDLE, `ptr[o]`←owner+1, wrapping N-1→0 (explicit compare, not modulo by power of two).
- `in_ready[i]`=0 for any input not currently an owner. An input owns at most one output (single destination).
- `select[o]` in IDLE holds the last owner (0 after reset); `out_valid[o]`=0 in IDLE.
- `in_dest` change while locked: ignored; owner stays until a last-beat transfer.
- `in_valid[owner]` dropping mid-packet: lock held, `out_valid[o]`=0, no release.

## Timing
- Reset (synchronous): all outputs IDLE, `owner`=0, `ptr`=0; `select`=0, `in_ready`=0, `out_valid`=0, `out_busy`=0 from the first cycle after `rst` sampled high.
- Grant latency: request first visible in cycle t → BUSY and first transfer possible in t+1.
- Release: last beat transfers in cycle t → IDLE in t+1; new arbitration in t+1, next packet transfers in t+2 (one bubble per packet; single-beat packets take 2 cycles each).
- `in_ready`, `out_valid`, `select` combinational from registered state plus `in_valid`/`out_ready`; no combinational path from `in_dest` to outputs in BUSY.
- Simultaneous requests to different outputs arbitrate independently in the same cycle.
- `rst` mid-packet: lock and pointer dropped; the in-flight packet is truncated and is the sender's concern.

## Structure
- Package `crossbar_pkg`: state enum (`XB_IDLE`, `XB_BUSY`) and a `sel_w(N)` function shared with the crossbar.
- Sub-module `rr_arbiter` (N-bit request vector, SEL_W pointer in, winner index + any-valid out; combinational), instantiated once per output in a generate loop; lock/pointer registers stay in `crossbar_scheduler`.

## Test plan
- Reset: drive requests during `rst`=1 → all outputs 0; after release, `select`=0 and `out_busy`=0 until the first grant.
- Single packet: input 1, dest 2, 3 beats, `out_ready`=1 → `out_busy[2]` rises cycle t+1, `select[2]`=1, 3 transfers t+1..t+3, IDLE t+4, `ptr[2]`=2.
- Contention: inputs 0,1,2 all dest 0, 1-beat packets, `out_ready`=1 → grant order 0,1,2,0 with one bubble between grants; the pointer wraps 2→0.
- Backpressure: `out_ready[0]` low for 4 cycles mid-packet → `in_ready[owner]`=0 those cycles, lock held, no beats lost or duplicated.
- Parallel: input 0→1 and input 2→0 simultaneously → both granted in the same cycle, `select` = {field0=2, field1=0}, independent release.
- Reset mid-packet plus N=4 (dest 3) and an invalid dest for N=3 → state cleared next cycle; dest 3 with N=3 never gets `in_ready`.
